// File: rtl/p405s_add_pkg.sv
// Shared helpers for the segmented adder pipeline: segment count, segment bit
// bounds and a parameter legality predicate evaluated at elaboration.
package p405s_add_pkg;

  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  // The top segment is truncated to whatever bits remain.
  function automatic int seg_hi(input int k, input int width, input int seg);
    int hi;
    hi = (k + 1) * seg - 1;
    return (hi > width - 1) ? width - 1 : hi;
  endfunction

  function automatic bit cfg_ok(input int width, input int seg);
    return (width >= 2) && (seg >= 1) && (seg <= width);
  endfunction

endpackage

// File: rtl/p405s_add_seg_stage.sv
// One pipeline stage: adds segment K of the skewed operands plus the carry from
// the previous stage, and registers it together with the travelling payload.
module p405s_add_seg_stage
  import p405s_add_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int SEG = 16,
  parameter int K = 0,
  localparam int NSEG = nseg(WIDTH, SEG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld_up,
  input  logic             sub_up,
  input  logic [WIDTH-1:0] a_up,
  input  logic [WIDTH-1:0] b_up,
  input  logic [WIDTH-1:0] sum_up,
  input  logic [NSEG-1:0]  seg_co_up,
  input  logic             c_up,
  output logic             vld,
  output logic             sub,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [NSEG-1:0]  seg_co,
  output logic             c,
  output logic             co_m
);

  localparam int LO = seg_lo(K, SEG);
  localparam int HI = seg_hi(K, WIDTH, SEG);
  localparam int SW = HI - LO + 1;

  logic [SW:0]       seg_add;
  logic [WIDTH-1:0]  sum_nxt;
  logic [NSEG-1:0]   seg_co_nxt;
  logic              co_m_nxt;

  assign seg_add = {1'b0, a_up[HI:LO]} + {1'b0, b_up[HI:LO]} + {{SW{1'b0}}, c_up};

  always_comb begin
    sum_nxt         = sum_up;
    sum_nxt[HI:LO]  = seg_add[SW-1:0];
    seg_co_nxt      = seg_co_up;
    seg_co_nxt[K]   = seg_add[SW];
  end

  // Carry into the segment's top bit recovered from its sum bit; only the
  // top stage's value is consumed, where it is the carry into bit WIDTH-1.
  assign co_m_nxt = seg_add[SW-1] ^ a_up[HI] ^ b_up[HI];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      sub    <= 1'b0;
      a      <= '0;
      b      <= '0;
      sum    <= '0;
      seg_co <= '0;
      c      <= 1'b0;
      co_m   <= 1'b0;
    end else if (en) begin
      vld    <= vld_up;
      sub    <= sub_up;
      a      <= a_up;
      b      <= b_up;
      sum    <= sum_nxt;
      seg_co <= seg_co_nxt;
      c      <= seg_add[SW];
      co_m   <= co_m_nxt;
    end
  end

endmodule

// File: rtl/p405s_add_seg_pipe.sv
// Pipelined segmented adder/subtractor: one register stage per SEG-bit slice
// of the carry chain, globally stalled by a single advance enable.
module p405s_add_seg_pipe
  import p405s_add_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int SEG = 16,
  localparam int NSEG = nseg(WIDTH, SEG)
) (
  input  logic             CB,
  input  logic             resetN,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic [NSEG-1:0]  SEG_CO,
  output logic             CO_M,
  output logic             OVF
);

  if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("p405s_add_seg_pipe: illegal WIDTH/SEG combination");
  end

  // Index 0 is the stage-0 input; index k+1 is the register of stage k.
  logic             vld_p    [NSEG+1];
  logic             sub_p    [NSEG+1];
  logic [WIDTH-1:0] a_p      [NSEG+1];
  logic [WIDTH-1:0] b_p      [NSEG+1];
  logic [WIDTH-1:0] sum_p    [NSEG+1];
  logic [NSEG-1:0]  seg_co_p [NSEG+1];
  logic             c_p      [NSEG+1];
  logic             co_m_p   [NSEG];
  logic             en;

  assign en     = !OUT_VLD || OUT_RDY;
  assign IN_RDY = en;

  assign vld_p[0]    = IN_VLD;
  assign sub_p[0]    = SUB;
  assign a_p[0]      = A;
  assign b_p[0]      = SUB ? ~B : B;
  assign sum_p[0]    = '0;
  assign seg_co_p[0] = '0;
  assign c_p[0]      = SUB | CI;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    p405s_add_seg_stage #(
      .WIDTH(WIDTH),
      .SEG  (SEG),
      .K    (k)
    ) u_stage (
      .clk      (CB),
      .rst_n    (resetN),
      .en       (en),
      .vld_up   (vld_p[k]),
      .sub_up   (sub_p[k]),
      .a_up     (a_p[k]),
      .b_up     (b_p[k]),
      .sum_up   (sum_p[k]),
      .seg_co_up(seg_co_p[k]),
      .c_up     (c_p[k]),
      .vld      (vld_p[k+1]),
      .sub      (sub_p[k+1]),
      .a        (a_p[k+1]),
      .b        (b_p[k+1]),
      .sum      (sum_p[k+1]),
      .seg_co   (seg_co_p[k+1]),
      .c        (c_p[k+1]),
      .co_m     (co_m_p[k])
    );
  end

  assign OUT_VLD = vld_p[NSEG];
  assign SUM     = sum_p[NSEG];
  assign SEG_CO  = seg_co_p[NSEG];
  assign CO      = c_p[NSEG];
  assign CO_M    = co_m_p[NSEG-1];
  assign OVF     = CO ^ CO_M;

endmodule

// File: tb/tb_p405s_add_seg_pipe.sv
// Scoreboard bench for the segmented adder pipeline (33/16 and 33/33 builds).
module tb_p405s_add_seg_pipe;

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic        ci;
    logic        sub;
    logic [32:0] sum;
    logic        co;
    logic [2:0]  seg_co;
    logic        co_m;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [32:0] sum;
    logic        co;
    logic [2:0]  seg_co;
    logic        co_m;
    logic        ovf;
    int          exp_cyc;
    bit          chk_lat;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0, in_rdy, out_vld, out_rdy = 1'b1;
  logic [32:0] a = '0, b = '0, sum;
  logic        ci = 1'b0, sub = 1'b0, co, co_m, ovf;
  logic [2:0]  seg_co;

  logic        in_vld_1 = 1'b0, in_rdy_1, out_vld_1;
  logic [32:0] a_1 = '0, b_1 = '0, sum_1;
  logic        ci_1 = 1'b0, sub_1 = 1'b0, co_1, co_m_1, ovf_1;
  logic [0:0]  seg_co_1;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  item_t sb[$];
  vec_t  vt[8];

  p405s_add_seg_pipe #(.WIDTH(33), .SEG(16)) dut (
    .CB(clk), .resetN(rst_n), .IN_VLD(in_vld), .IN_RDY(in_rdy), .A(a), .B(b),
    .CI(ci), .SUB(sub), .OUT_VLD(out_vld), .OUT_RDY(out_rdy), .SUM(sum), .CO(co),
    .SEG_CO(seg_co), .CO_M(co_m), .OVF(ovf));

  p405s_add_seg_pipe #(.WIDTH(33), .SEG(33)) dut1 (
    .CB(clk), .resetN(rst_n), .IN_VLD(in_vld_1), .IN_RDY(in_rdy_1), .A(a_1), .B(b_1),
    .CI(ci_1), .SUB(sub_1), .OUT_VLD(out_vld_1), .OUT_RDY(1'b1), .SUM(sum_1), .CO(co_1),
    .SEG_CO(seg_co_1), .CO_M(co_m_1), .OVF(ovf_1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {63'd0, out_vld}, 64'd0);
      end else begin
        check("sum", {31'd0, sum}, {31'd0, sb[0].sum});
        check("co", {63'd0, co}, {63'd0, sb[0].co});
        check("seg_co", {61'd0, seg_co}, {61'd0, sb[0].seg_co});
        check("co_m", {63'd0, co_m}, {63'd0, sb[0].co_m});
        check("ovf", {63'd0, ovf}, {63'd0, sb[0].ovf});
        if (!out_rdy) begin
          check("stall_in_rdy", {63'd0, in_rdy}, 64'd0);
        end else begin
          check("drain_in_rdy", {63'd0, in_rdy}, 64'd1);
          if (sb[0].chk_lat) check("latency", 64'(cyc), 64'(sb[0].exp_cyc));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input int idx, input bit lat);
    int    waits = 0;
    item_t it;
    @(negedge clk);
    in_vld = 1'b1;
    a = vt[idx].a;
    b = vt[idx].b;
    ci = vt[idx].ci;
    sub = vt[idx].sub;
    #1;
    while (!in_rdy && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_rdy) begin
      check("issue_timeout", 64'd0, 64'd1);
    end else begin
      it.sum = vt[idx].sum;
      it.co = vt[idx].co;
      it.seg_co = vt[idx].seg_co;
      it.co_m = vt[idx].co_m;
      it.ovf = vt[idx].ovf;
      it.exp_cyc = cyc + 3;
      it.chk_lat = lat;
      sb.push_back(it);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    //        a              b              ci    sub   sum            co    seg_co  co_m  ovf
    vt[0] = '{33'h0_0000_FFFF, 33'h0_0000_0001, 1'b0, 1'b0, 33'h0_0001_0000, 1'b0, 3'b001, 1'b0, 1'b0};
    vt[1] = '{33'h1_FFFF_FFFF, 33'h0_0000_0000, 1'b1, 1'b0, 33'h0_0000_0000, 1'b1, 3'b111, 1'b1, 1'b0};
    vt[2] = '{33'h0_0000_0005, 33'h0_0000_0007, 1'b1, 1'b1, 33'h1_FFFF_FFFE, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[3] = '{33'h0_0000_0007, 33'h0_0000_0005, 1'b0, 1'b1, 33'h0_0000_0002, 1'b1, 3'b111, 1'b1, 1'b0};
    vt[4] = '{33'h0_FFFF_FFFF, 33'h0_0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, 3'b011, 1'b1, 1'b1};
    vt[5] = '{33'h0_0000_0000, 33'h0_0000_0000, 1'b0, 1'b0, 33'h0_0000_0000, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[6] = '{33'h1_2345_6789, 33'h0_1111_1111, 1'b0, 1'b0, 33'h1_3456_789A, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[7] = '{33'h1_0000_0000, 33'h1_0000_0000, 1'b0, 1'b0, 33'h0_0000_0000, 1'b1, 3'b100, 1'b0, 1'b1};

    #2;
    check("rst_out_vld", {63'd0, out_vld}, 64'd0);
    check("rst_sum", {31'd0, sum}, 64'd0);
    check("rst_flags", {60'd0, seg_co, co, co_m, ovf}, 64'd0);
    check("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream, exact latency.
    for (int i = 0; i < 8; i++) issue(i, 1'b1);
    idle();
    drain();

    // Backpressure: two stall cycles once the first of three is valid.
    issue(2, 1'b0);
    issue(3, 1'b0);
    issue(4, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    out_rdy = 1'b0;
    #1;
    check("bp_first_valid", {63'd0, out_vld}, 64'd1);
    check("bp_in_rdy_low", {63'd0, in_rdy}, 64'd0);
    repeat (2) @(negedge clk);
    out_rdy = 1'b1;
    drain();

    // Reset with operations in flight, first result being held.
    issue(6, 1'b0);
    issue(4, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);
    #3;
    check("pre_rst_valid", {63'd0, out_vld}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", {63'd0, out_vld}, 64'd0);
    check("mid_rst_sum", {31'd0, sum}, 64'd0);
    check("mid_rst_flags", {60'd0, seg_co, co, co_m, ovf}, 64'd0);
    check("mid_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("post_rst_no_stale", {63'd0, out_vld}, 64'd0);

    // Single-segment build: latency 1.
    @(negedge clk);
    in_vld_1 = 1'b1;
    a_1 = 33'h0_0000_FFFF;
    b_1 = 33'h0_0000_0001;
    ci_1 = 1'b0;
    sub_1 = 1'b0;
    #1;
    check("n1_in_rdy", {63'd0, in_rdy_1}, 64'd1);
    check("n1_not_yet", {63'd0, out_vld_1}, 64'd0);
    @(negedge clk);
    in_vld_1 = 1'b1;
    a_1 = 33'h0_0000_0005;
    b_1 = 33'h0_0000_0007;
    sub_1 = 1'b1;
    #2;
    check("n1_vld", {63'd0, out_vld_1}, 64'd1);
    check("n1_sum", {31'd0, sum_1}, 64'h0_0001_0000);
    check("n1_flags", {60'd0, seg_co_1, co_1, co_m_1, ovf_1}, 64'd0);
    @(negedge clk);
    in_vld_1 = 1'b0;
    #2;
    check("n1_sub_vld", {63'd0, out_vld_1}, 64'd1);
    check("n1_sub_sum", {31'd0, sum_1}, 64'h1_FFFF_FFFE);
    check("n1_sub_co", {62'd0, seg_co_1, co_1}, 64'd0);
    @(negedge clk);
    #2;
    check("n1_single", {63'd0, out_vld_1}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
